// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM encoding, round constants, IV and the
// bitwise helper functions used by the compression datapath.
package sha256_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      EXPAND = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef struct packed {
      logic [31:0] a, b, c, d, e, f, g, h;
   } work_t;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   // One compression round; additions wrap modulo 2^32 by width.
   function automatic work_t sha_round(input work_t s, input logic [31:0] k, input logic [31:0] w);
      logic [31:0] t1;
      logic [31:0] t2;
      work_t r;
      t1 = s.h + big_sigma1(s.e) + ch(s.e, s.f, s.g) + k + w;
      t2 = big_sigma0(s.a) + maj(s.a, s.b, s.c);
      r.a = t1 + t2;
      r.b = s.a;
      r.c = s.b;
      r.d = s.c;
      r.e = s.d + t1;
      r.f = s.e;
      r.g = s.f;
      r.h = s.g;
      return r;
   endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational lookup of the SHA-256 round constant Kt.
module sha256_k_rom
   import sha256_pkg::*;
(
   input  logic [5:0]  idx,
   output logic [31:0] k
);

   assign k = K[idx];

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 single-block compression: 16 streamed rounds, 48 expanded rounds,
// final working state reported without the feed-forward add.
module sha256_compress
   import sha256_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] h_in,
   input  logic         w_valid,
   input  logic [31:0]  w_in,
   output logic         w_ready,
   output logic         busy,
   output logic         done,
   output logic [255:0] state_out,
   output logic [31:0]  e_out
);

   state_t       state_reg;
   logic [5:0]   round_reg;
   logic         last_reg;
   logic         w_ready_reg;
   logic         busy_reg;
   logic         done_reg;
   logic [255:0] state_out_reg;
   work_t        work_reg;
   logic [31:0]  win_reg [16];
   logic [31:0]  win_next [16];
   logic [31:0]  k_t;
   logic [31:0]  w_t;
   logic [31:0]  w_exp;
   logic         load_xfer;
   logic         exp_step;

   sha256_k_rom u_k_rom (
      .idx (round_reg),
      .k   (k_t)
   );

   assign load_xfer = (state_reg == LOAD) && w_valid;
   assign exp_step  = (state_reg == EXPAND) && !last_reg;

   // win_reg[15] is W[t-1], win_reg[0] is W[t-16].
   assign w_exp = small_sigma1(win_reg[14]) + win_reg[9] + small_sigma0(win_reg[1]) + win_reg[0];
   assign w_t   = (state_reg == LOAD) ? w_in : w_exp;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_win
         if (gi < 15) begin : g_shift
            assign win_next[gi] = win_reg[gi + 1];
         end else begin : g_tail
            assign win_next[gi] = w_t;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (load_xfer || exp_step) begin
         win_reg <= win_next;
      end
   end

   always_ff @(posedge clk) begin
      if (state_reg == IDLE && start) begin
         work_reg <= h_in;
      end else if (load_xfer || exp_step) begin
         work_reg <= sha_round(work_reg, k_t, w_t);
      end
   end

   // last_reg adds the settle cycle after round 63 so done lands 49 cycles after W15.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         round_reg     <= '0;
         last_reg      <= 1'b0;
         w_ready_reg   <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         state_out_reg <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg   <= LOAD;
                  round_reg   <= '0;
                  last_reg    <= 1'b0;
                  w_ready_reg <= 1'b1;
                  busy_reg    <= 1'b1;
               end
            end
            LOAD: begin
               if (w_valid) begin
                  round_reg <= round_reg + 6'd1;
                  if (round_reg == 6'd15) begin
                     state_reg   <= EXPAND;
                     w_ready_reg <= 1'b0;
                  end
               end
            end
            EXPAND: begin
               if (last_reg) begin
                  state_reg     <= DONE;
                  done_reg      <= 1'b1;
                  state_out_reg <= work_reg;
               end else if (round_reg == 6'd63) begin
                  last_reg <= 1'b1;
               end else begin
                  round_reg <= round_reg + 6'd1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign w_ready   = w_ready_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign state_out = state_out_reg;
   assign e_out     = state_out_reg[127:96];

endmodule

// File: doc/sha256_compress.md
SHA256_COMPRESS -- requirements
Module: sha256_compress

Interface
REQ-001 clk  input  1  rising-edge clock; single clock domain.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 start  input  1  begin one block compression; honoured only in IDLE.
REQ-004 h_in  input  256  initial working state {a,b,c,d,e,f,g,h}, a in bits 255:224; sampled on an accepted start.
REQ-005 w_valid  input  1  message word on w_in is valid.
REQ-006 w_in  input  32  message word W0..W15 in order, big-endian word value.
REQ-007 w_ready  output  1  block accepts a word this cycle; transfer = w_valid & w_ready.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse: final working state valid.
REQ-010 state_out  output  256  final {a..h} after round 63, no feed-forward add; same packing as h_in.
REQ-011 e_out  output  32  equals state_out[127:96]; feeds the downstream H-register accumulator.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, EXPAND, DONE.
REQ-013 IDLE: on start=1, the block SHALL load a..h from h_in, clear the round counter, and enter LOAD next cycle.
REQ-014 LOAD: w_ready SHALL be 1; each transfer SHALL execute round t (t=0..15) using Wt=w_in, and push w_in into a 16-word window.
REQ-015 LOAD with w_valid=0 SHALL hold a..h, counter and window unchanged (stall of any length).
REQ-016 After the 16th transfer (t=15), the block SHALL enter EXPAND the next cycle.
REQ-017 EXPAND: w_ready=0; one round per cycle for t=16..63 with Wt = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16]; window shifts each round.
REQ-018 After round 63, the block SHALL enter DONE: done=1 for exactly one cycle, then IDLE.
REQ-019 Latency: done SHALL assert exactly 49 cycles after the clock edge accepting W15.
REQ-020 Round: T1 = h + Σ1(e) + Ch(e,f,g) + Kt + Wt; T2 = Σ0(a) + Maj(a,b,c); new {a..h} = {T1+T2, a, b, c, d+T1, e, f, g}.
REQ-021 All additions SHALL be modulo 2^32; carries are discarded.
REQ-022 state_out/e_out SHALL update only on entry to DONE and hold until the next entry to DONE or reset.
REQ-023 start while busy SHALL be ignored; w_valid outside LOAD SHALL be ignored.
REQ-024 start asserted in the DONE cycle SHALL be ignored; a new start is accepted from IDLE, one cycle after done.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, round counter 0, w_ready=0, busy=0, done=0, state_out=0, e_out=0, regardless of current state.
REQ-026 Reset mid-block SHALL abandon the block; no done pulse SHALL follow until a new start completes.
REQ-027 Internal window and working registers need no reset value; they are reloaded on every accepted start.

Structure
REQ-028 Package sha256_pkg SHALL hold: FSM state encoding, the 64 Kt constants, the IV constants, and the Σ0, Σ1, σ0, σ1, Ch, Maj functions.
REQ-029 Sub-module sha256_k_rom SHALL be combinational: 6-bit round index in, 32-bit Kt out.
REQ-030 Round counter SHALL be 6 bits and terminal at 63; no wrap into a second pass.

Verification
REQ-031 "abc" block: h_in=IV, W0=0x61626380, W1..W14=0, W15=0x00000018, w_valid always 1 -> done 49 cycles after W15, state_out[255:224]=0x506E3058, e_out=0x5EF50F24.
REQ-032 Same block with w_valid low for 3 cycles between each word -> identical state_out; done still 49 cycles after W15.
REQ-033 start pulsed during EXPAND -> ignored; exactly one done pulse; state_out unchanged vs REQ-031.
REQ-034 rst at round 30 -> next cycle busy=0, state_out=0, no done; a subsequent "abc" run reproduces the REQ-031 results.
REQ-035 Two back-to-back blocks, start issued the cycle after done -> each done pulse carries its own correct state_out; the first value holds until the second done.
